// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory responder and its storage array.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEPTH_DEF   = 32;
    localparam int LATENCY_DEF = 3;
    localparam int WORD_OFFSET = 2;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage: synchronous write, combinational read on a shared index.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [idx_w(DEPTH)-1:0] idx_i,
    input  logic [31:0]             wdata_i,
    output logic [31:0]             rdata_o
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[idx_i];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder: accepts one CPU request, stalls the pipeline,
// and completes with a single-cycle ack carrying read data or an error flag.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int IDX_W = idx_w(DEPTH);

    state_t              state, state_nxt;
    logic [3:0]          cnt;
    logic                cap_we;
    logic [31:0]         cap_addr;
    logic [31:0]         cap_wdata;
    logic                err_q;
    logic                accept;
    logic                done_enter;
    logic                sel_we;
    logic [31:0]         sel_addr;
    logic [31:0]         sel_wdata;
    logic [31-WORD_OFFSET:0] sel_index;
    logic                sel_err;
    logic [IDX_W-1:0]    sel_idx;
    logic [31:0]         mem_rdata;
    logic                mem_we;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        done_enter = 1'b0;
        stall_o    = 1'b0;
        ack_o      = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_i) begin
                    stall_o = 1'b1;
                    accept  = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt  = DONE;
                        done_enter = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (cnt == 4'd1) begin
                    state_nxt  = DONE;
                    done_enter = 1'b1;
                end
            end
            DONE: begin
                ack_o     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With LATENCY=1 the completion edge is also the accept edge, so the live inputs
    // stand in for the not-yet-captured transaction.
    assign sel_we    = (state == IDLE) ? we_i    : cap_we;
    assign sel_addr  = (state == IDLE) ? addr_i  : cap_addr;
    assign sel_wdata = (state == IDLE) ? wdata_i : cap_wdata;
    assign sel_index = sel_addr[31:WORD_OFFSET];
    assign sel_err   = (sel_addr[WORD_OFFSET-1:0] != '0) || (32'(sel_index) >= 32'(DEPTH));
    assign sel_idx   = sel_index[IDX_W-1:0];
    assign mem_we    = done_enter && sel_we && !sel_err && !rst_i;
    assign err_o     = ack_o & err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rdata_o   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                cap_we    <= we_i;
                cap_addr  <= addr_i;
                cap_wdata <= wdata_i;
                cnt       <= 4'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (done_enter) begin
                err_q <= sel_err;
                if (sel_err) begin
                    rdata_o <= '0;
                end else if (!sel_we) begin
                    rdata_o <= mem_rdata;
                end
            end
        end
    end

    mem_array #(
        .DEPTH(DEPTH)
    ) u_mem_array (
        .clk_i  (clk_i),
        .we_i   (mem_we),
        .idx_i  (sel_idx),
        .wdata_i(sel_wdata),
        .rdata_o(mem_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed bench for data_mem_responder against a word-array reference model.
module tb_data_mem_responder;

    localparam int DEPTH = 32;
    localparam int LAT   = 3;

    logic        clk;
    logic        rst;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic        ack, stall, err;
    logic [31:0] rdata;
    logic        req1, we1;
    logic [31:0] addr1, wdata1;
    logic        ack1, stall1, err1;
    logic [31:0] rdata1;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_rd;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .ack_o(ack), .rdata_o(rdata), .stall_o(stall), .err_o(err)
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we1), .addr_i(addr1), .wdata_i(wdata1),
        .ack_o(ack1), .rdata_o(rdata1), .stall_o(stall1), .err_o(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= DEPTH);
    endfunction

    // Reference model: completes a transaction and returns the expected error flag.
    function automatic bit model_apply(input logic w, input logic [31:0] a, input logic [31:0] d);
        bit e = addr_bad(a);
        if (e) exp_rd = 32'h0;
        else if (!w) exp_rd = model_mem[a / 4];
        else model_mem[a / 4] = d;
        return e;
    endfunction

    // Drives one request on the LATENCY=3 instance from an IDLE cycle; req stays high
    // through the ack cycle unless dropped after cycle drop_after.
    task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int drop_after, output int lat, output int stalls,
                           output logic e, output logic [31:0] rd);
        lat = -1; stalls = 0; e = 1'b0; rd = 32'h0;
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (ack) begin
                lat = c; e = err; rd = rdata;
            end
            @(posedge clk); #1;
            if (c == drop_after) begin
                req = 1'b0; we = ~w; addr = $urandom; wdata = $urandom;
            end
        end
        req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got=%b exp=0", ack); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        req = 1'b1;
        @(negedge clk);
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL reset_stall_req got=%b exp=1", stall); end
        @(posedge clk); #1;
        req = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (ack !== 1'b0 || stall !== 1'b0) begin
            n_bad++; $display("FAIL reset_no_accept ack=%b stall=%b exp 0/0", ack, stall);
        end
        exp_rd = 32'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_init_zero();
        int l, s; logic e; logic [31:0] rd;
        for (int i = 0; i < DEPTH; i++) begin
            run_txn(1'b1, 32'(i) * 4, 32'h0, -1, l, s, e, rd);
            void'(model_apply(1'b1, 32'(i) * 4, 32'h0));
            n_cmp++; if (l !== LAT || e !== 1'b0) begin
                n_bad++; $display("FAIL init_write[%0d] lat=%0d err=%b exp lat=%0d err=0", i, l, e, LAT);
            end
        end
    endtask

    task automatic test_directed();
        int l, s; logic e; logic [31:0] rd; bit xe;
        run_txn(1'b1, 32'h10, 32'hDEADBEEF, -1, l, s, e, rd);
        void'(model_apply(1'b1, 32'h10, 32'hDEADBEEF));
        n_cmp++; if (s !== 3) begin n_bad++; $display("FAIL wr10_stalls got=%0d exp=3", s); end
        n_cmp++; if (l !== 3) begin n_bad++; $display("FAIL wr10_lat got=%0d exp=3", l); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL wr10_err got=%b exp=0", e); end
        n_cmp++; if (rd !== exp_rd) begin n_bad++; $display("FAIL wr10_rdata_hold got=%h exp=%h", rd, exp_rd); end
        run_txn(1'b0, 32'h10, 32'h0, -1, l, s, e, rd);
        n_cmp++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
            n_bad++; $display("FAIL rd10 got=%h err=%b exp=deadbeef err=0", rd, e);
        end
        void'(model_apply(1'b0, 32'h10, 32'h0));
        foreach (model_mem[k]) begin end
        for (int k = 0; k < 3; k++) begin
            logic [31:0] a;
            logic w;
            a = (k == 0) ? 32'h12 : (k == 1) ? 32'h80 : 32'h11;
            w = (k == 2);
            run_txn(w, a, 32'hFFFF_FFFF, -1, l, s, e, rd);
            xe = model_apply(w, a, 32'hFFFF_FFFF);
            n_cmp++; if (e !== 1'b1 || rd !== 32'h0 || l !== 3) begin
                n_bad++; $display("FAIL bad_addr[%h] err=%b rd=%h lat=%0d exp err=%b rd=0 lat=3", a, e, rd, l, xe);
            end
        end
        run_txn(1'b0, 32'h10, 32'h0, -1, l, s, e, rd);
        void'(model_apply(1'b0, 32'h10, 32'h0));
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd10_after_err got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_back_to_back();
        int l, s; logic e; logic [31:0] rd;
        run_txn(1'b1, 32'h4, 32'h1, -1, l, s, e, rd);
        void'(model_apply(1'b1, 32'h4, 32'h1));
        run_txn(1'b0, 32'h4, 32'h0, -1, l, s, e, rd);
        void'(model_apply(1'b0, 32'h4, 32'h0));
        n_cmp++; if (l !== 3) begin n_bad++; $display("FAIL b2b_lat got=%0d exp=3", l); end
        n_cmp++; if (s !== 3) begin n_bad++; $display("FAIL b2b_stalls got=%0d exp=3", s); end
        n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL b2b_rdata got=%h exp=00000001", rd); end
    endtask

    task automatic test_drop_req();
        int l, s; logic e; logic [31:0] rd; logic [31:0] v;
        v = $urandom;
        run_txn(1'b1, 32'h14, v, 0, l, s, e, rd);
        void'(model_apply(1'b1, 32'h14, v));
        n_cmp++; if (l !== 3 || s !== 3) begin n_bad++; $display("FAIL drop_wr lat=%0d stalls=%0d exp 3/3", l, s); end
        run_txn(1'b0, 32'h14, 32'h0, 0, l, s, e, rd);
        void'(model_apply(1'b0, 32'h14, 32'h0));
        n_cmp++; if (l !== 3 || rd !== v) begin n_bad++; $display("FAIL drop_rd lat=%0d rd=%h exp 3/%h", l, rd, v); end
    endtask

    task automatic test_reset_mid();
        int l, s; logic e; logic [31:0] rd; bit seen;
        for (int d = 1; d <= 2; d++) begin
            @(posedge clk); #1;
            req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'h55;
            repeat (d) begin @(posedge clk); #1; req = 1'b0; end
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            exp_rd = 32'h0;
            seen = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (ack) seen = 1;
                @(posedge clk); #1;
            end
            n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_ack[%0d] got=1 exp=0", d); end
            @(negedge clk);
            n_cmp++; if (stall !== 1'b0 || rdata !== 32'h0) begin
                n_bad++; $display("FAIL midrst_idle[%0d] stall=%b rdata=%h exp 0/0", d, stall, rdata);
            end
            @(posedge clk); #1;
            run_txn(1'b0, 32'h8, 32'h0, -1, l, s, e, rd);
            void'(model_apply(1'b0, 32'h8, 32'h0));
            n_cmp++; if (rd !== exp_rd || rd !== 32'h0) begin
                n_bad++; $display("FAIL midrst_rd8[%0d] got=%h exp=00000000", d, rd);
            end
        end
    endtask

    task automatic test_random();
        int l, s, drop, sel; logic e, w, xe; logic [31:0] rd, a, d;
        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 7) a = 32'($urandom_range(0, DEPTH - 1)) * 4;
            else if (sel == 7) a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
            else if (sel == 8) a = 32'($urandom_range(DEPTH, 4 * DEPTH)) * 4;
            else a = $urandom | 32'h8000_0000;
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1;
            run_txn(w, a, d, drop, l, s, e, rd);
            xe = model_apply(w, a, d);
            n_cmp++; if (l !== LAT) begin n_bad++; $display("FAIL rnd_lat[%0d] got=%0d exp=%0d", i, l, LAT); end
            n_cmp++; if (s !== LAT) begin n_bad++; $display("FAIL rnd_stalls[%0d] got=%0d exp=%0d", i, s, LAT); end
            n_cmp++; if (e !== xe) begin n_bad++; $display("FAIL rnd_err[%0d] a=%h got=%b exp=%b", i, a, e, xe); end
            n_cmp++; if (rd !== exp_rd) begin n_bad++; $display("FAIL rnd_rdata[%0d] a=%h got=%h exp=%h", i, a, rd, exp_rd); end
        end
        @(negedge clk);
        n_cmp++; if (rdata !== exp_rd || err !== 1'b0) begin
            n_bad++; $display("FAIL rnd_hold rdata=%h err=%b exp %h/0", rdata, err, exp_rd);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_latency1();
        logic [31:0] v;
        v = $urandom;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            req1 = 1'b1; we1 = (k == 0); wdata1 = v;
            addr1 = (k == 2) ? 32'h81 : 32'h0;
            @(negedge clk);
            n_cmp++; if (stall1 !== 1'b1 || ack1 !== 1'b0) begin
                n_bad++; $display("FAIL lat1_accept[%0d] stall=%b ack=%b exp 1/0", k, stall1, ack1);
            end
            @(posedge clk); #1;
            req1 = 1'b0;
            @(negedge clk);
            n_cmp++; if (ack1 !== 1'b1 || stall1 !== 1'b0 || err1 !== (k == 2)) begin
                n_bad++; $display("FAIL lat1_ack[%0d] ack=%b stall=%b err=%b exp 1/0/%b", k, ack1, stall1, err1, k == 2);
            end
            if (k == 1) begin
                n_cmp++; if (rdata1 !== v) begin n_bad++; $display("FAIL lat1_rdata got=%h exp=%h", rdata1, v); end
            end
            if (k == 2) begin
                n_cmp++; if (rdata1 !== 32'h0) begin n_bad++; $display("FAIL lat1_err_rdata got=%h exp=0", rdata1); end
            end
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++; if (ack1 !== 1'b0) begin n_bad++; $display("FAIL lat1_pulse[%0d] ack=%b exp=0", k, ack1); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_init_zero();
        test_directed();
        test_back_to_back();
        test_drop_req();
        test_reset_mid();
        test_random();
        test_latency1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 32, number of 32-bit words stored.
REQ-002 Parameter LATENCY, default 3, request-accept-to-ack latency in cycles; legal range 1..15.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 req_i  input  1  CPU memory request valid (MEM-stage MemRead or MemWrite).
REQ-006 we_i  input  1  1 = write, 0 = read; sampled with req_i.
REQ-007 addr_i  input  32  byte address from EX/MEM ALU result.
REQ-008 wdata_i  input  32  store data.
REQ-009 ack_o  output  1  one-cycle completion pulse.
REQ-010 rdata_o  output  32  read data; valid when ack_o=1 for a read.
REQ-011 stall_o  output  1  pipeline freeze request to CPU (PC, IF/ID, ID/EX, EX/MEM hold).
REQ-012 err_o  output  1  error flag; valid only with ack_o.

Function
REQ-013 FSM states: IDLE, WAIT, DONE.
REQ-014 IDLE with req_i=1: capture we_i/addr_i/wdata_i; load counter with LATENCY-1; go WAIT (LATENCY>1) or DONE (LATENCY=1).
REQ-015 WAIT: decrement counter each cycle; at counter=1 go DONE next edge; req_i/we_i/addr_i/wdata_i ignored.
REQ-016 req_i deasserting during WAIT does not abort; captured transaction completes.
REQ-017 ack_o=1 exactly in the DONE cycle, which is LATENCY cycles after the accept cycle; DONE always returns to IDLE next edge.
REQ-018 Request present during DONE is not accepted; it is accepted in the following IDLE cycle.
REQ-019 stall_o = (state==IDLE and req_i) or state==WAIT; stall_o=0 in DONE so the CPU advances in the ack cycle.
REQ-020 Word index = captured addr[31:2]; error when addr[1:0]!=0 or index>=DEPTH.
REQ-021 Write without error: storage word updated at the edge entering DONE.
REQ-022 Read without error: rdata_o registered with the word at the edge entering DONE; reads return the latest completed write.
REQ-023 Any error: no storage update, rdata_o=0, err_o=1 in the DONE cycle.
REQ-024 rdata_o holds its last value outside DONE and on error-free writes.
REQ-025 err_o=0 whenever ack_o=0.

Reset
REQ-026 rst_i=1 at an edge: state IDLE, counter 0, ack_o=0, err_o=0, rdata_o=0, captured registers 0; stall_o then follows REQ-019.
REQ-027 Reset mid-transaction discards it; a pending write never reaches storage.
REQ-028 Storage contents are not cleared by reset.
REQ-029 rst_i has priority over every other event in the same cycle.

Structure
REQ-030 Shared package mem_pkg holds the state enum, default DEPTH/LATENCY constants, and the word-offset constant (2).
REQ-031 One sub-module, mem_array: DEPTH x 32 storage, synchronous write, combinational read; FSM/counter in data_mem_responder.

Verification
REQ-032 LATENCY=3: write 0xDEADBEEF to 0x10 with req_i held -> stall_o=1 for 3 cycles, ack_o pulses cycle 4, err_o=0; read 0x10 -> rdata_o=0xDEADBEEF with ack.
REQ-033 Read 0x12 (misaligned) and 0x80 (index 32) -> ack_o with err_o=1, rdata_o=0; follow-up read 0x10 still returns 0xDEADBEEF.
REQ-034 Back-to-back: req_i kept high across write 0x4=0x1 then read 0x4 -> second accepted cycle after DONE, returns 0x00000001; ack_o never high two consecutive cycles.
REQ-035 rst_i pulsed in WAIT of write 0x8=0x55 -> state IDLE, ack_o never pulses, later read 0x8 returns prior value (0x0 after initial write of 0).
REQ-036 LATENCY=1: read 0x0 -> stall_o=1 accept cycle only, ack_o next cycle.
REQ-037 req_i dropped one cycle after accept -> ack_o still pulses at LATENCY, data correct.
